// File: rtl/eei.sv
// Shared environment constants and types used by the memory-bus blocks.
// Widths come from here so every requester and the arbiter agree.
// The owner enum is also visible to trace/debug logic.
package eei;

   localparam int XLEN              = 32;
   localparam int MEMBUS_DATA_WIDTH = 32;

   // Requester that currently holds the single outstanding downstream transaction.
   typedef enum logic [1:0] {
      NONE   = 2'd0,
      IFETCH = 2'd1,
      DATA   = 2'd2
   } MembusOwner;

endpackage

// File: rtl/membus_arbiter.sv
// Arbitrates the instruction-fetch and load/store requesters onto one downstream membus.
// Latency: zero; both the request and the response path are combinational from the owner register.
// Backpressure: downstream ready reaches only the selected requester; one transaction outstanding at a time.
module membus_arbiter
   import eei::*;
#(
   parameter logic ALTERNATE = 1'b0
) (
   input  logic                           clk,
   input  logic                           rst,
   // instruction-fetch requester
   input  logic                           i_membus_valid_i,
   output logic                           i_membus_ready_o,
   input  logic [XLEN-1:0]                i_membus_addr_i,
   input  logic                           i_membus_wen_i,
   input  logic [MEMBUS_DATA_WIDTH-1:0]   i_membus_wdata_i,
   input  logic [MEMBUS_DATA_WIDTH/8-1:0] i_membus_wmask_i,
   output logic                           i_membus_rvalid_o,
   output logic [MEMBUS_DATA_WIDTH-1:0]   i_membus_rdata_o,
   // load/store requester
   input  logic                           d_membus_valid_i,
   output logic                           d_membus_ready_o,
   input  logic [XLEN-1:0]                d_membus_addr_i,
   input  logic                           d_membus_wen_i,
   input  logic [MEMBUS_DATA_WIDTH-1:0]   d_membus_wdata_i,
   input  logic [MEMBUS_DATA_WIDTH/8-1:0] d_membus_wmask_i,
   output logic                           d_membus_rvalid_o,
   output logic [MEMBUS_DATA_WIDTH-1:0]   d_membus_rdata_o,
   // downstream port toward the MMIO controller
   output logic                           membus_valid_o,
   input  logic                           membus_ready_i,
   output logic [XLEN-1:0]                membus_addr_o,
   output logic                           membus_wen_o,
   output logic [MEMBUS_DATA_WIDTH-1:0]   membus_wdata_o,
   output logic [MEMBUS_DATA_WIDTH/8-1:0] membus_wmask_o,
   input  logic                           membus_rvalid_i,
   input  logic [MEMBUS_DATA_WIDTH-1:0]   membus_rdata_i,
   // current owner, exported for trace/debug
   output logic [1:0]                     owner_o
);

   MembusOwner owner_q;
   MembusOwner owner_d;
   MembusOwner last_grant_q;
   MembusOwner last_grant_d;
   MembusOwner sel;
   logic       free;
   logic       handshake;

   // Request mux: pick a requester when the downstream port is free and compute the next owner.
   always_comb begin
      // The port frees up in the same cycle the outstanding response returns,
      // which is what allows a new grant back-to-back with a completion.
      free = (owner_q == NONE) || membus_rvalid_i;

      sel = NONE;
      if (i_membus_valid_i && d_membus_valid_i) begin
         if (ALTERNATE && (last_grant_q == DATA)) begin
            sel = IFETCH;
         end else begin
            sel = DATA;
         end
      end else if (d_membus_valid_i) begin
         sel = DATA;
      end else if (i_membus_valid_i) begin
         sel = IFETCH;
      end
      if (rst || !free) begin
         sel = NONE;
      end

      membus_valid_o   = 1'b0;
      membus_addr_o    = '0;
      membus_wen_o     = 1'b0;
      membus_wdata_o   = '0;
      membus_wmask_o   = '0;
      i_membus_ready_o = 1'b0;
      d_membus_ready_o = 1'b0;
      case (sel)
         IFETCH: begin
            membus_valid_o   = 1'b1;
            membus_addr_o    = i_membus_addr_i;
            membus_wen_o     = i_membus_wen_i;
            membus_wdata_o   = i_membus_wdata_i;
            membus_wmask_o   = i_membus_wmask_i;
            i_membus_ready_o = membus_ready_i;
         end
         DATA: begin
            membus_valid_o   = 1'b1;
            membus_addr_o    = d_membus_addr_i;
            membus_wen_o     = d_membus_wen_i;
            membus_wdata_o   = d_membus_wdata_i;
            membus_wmask_o   = d_membus_wmask_i;
            d_membus_ready_o = membus_ready_i;
         end
         default: ;
      endcase

      // A new grant takes priority over the completion arriving in the same cycle.
      handshake    = (sel != NONE) && membus_ready_i;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      if (handshake) begin
         owner_d      = sel;
         last_grant_d = sel;
      end else if (membus_rvalid_i) begin
         owner_d = NONE;
      end
   end

   // Response demux: steer the downstream response to the owner; a response with no owner is dropped.
   always_comb begin
      i_membus_rvalid_o = 1'b0;
      i_membus_rdata_o  = '0;
      d_membus_rvalid_o = 1'b0;
      d_membus_rdata_o  = '0;
      if (!rst) begin
         case (owner_q)
            IFETCH: begin
               i_membus_rvalid_o = membus_rvalid_i;
               i_membus_rdata_o  = membus_rdata_i;
            end
            DATA: begin
               d_membus_rvalid_o = membus_rvalid_i;
               d_membus_rdata_o  = membus_rdata_i;
            end
            default: ;
         endcase
      end
   end

   // Owner and last-grant registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= NONE;
         last_grant_q <= IFETCH;
      end else begin
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign owner_o = owner_q;

endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 SHALL have parameter ALTERNATE, default 1'b0; 0 = data port has fixed priority, 1 = grant alternates when both ports request.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port i_membus, Membus.slave, XLEN addr / MEMBUS_DATA_WIDTH data; instruction-fetch requester.
REQ-005 SHALL have port d_membus, Membus.slave, same widths; load/store requester.
REQ-006 SHALL have port membus, Membus.master, same widths; single port toward the MMIO controller.

Function
REQ-007 SHALL keep owner register (NONE, IFETCH, DATA) naming the requester of the one outstanding downstream transaction.
REQ-008 SHALL consider the port free when owner == NONE, or owner != NONE and membus.rvalid == 1 in the current cycle.
REQ-009 SHALL, when free, select combinationally: only one valid -> that port; both valid and ALTERNATE == 0 -> DATA; both valid and ALTERNATE == 1 -> the port not granted last (last_grant register, reset value IFETCH, so DATA wins first).
REQ-010 SHALL drive membus.valid/addr/wen/wdata/wmask from the selected port only when free; otherwise drive membus.valid = 0 and addr/wen/wdata/wmask = 0.
REQ-011 SHALL drive membus.ready to the selected port's ready; the non-selected port's ready = 0; both ready = 0 when not free.
REQ-012 SHALL, on membus.valid && membus.ready, set owner to the selected port next cycle and update last_grant to it.
REQ-013 SHALL, on membus.rvalid with no new handshake in that cycle, set owner to NONE next cycle.
REQ-014 SHALL route membus.rvalid/rdata to the owner's rvalid/rdata in the same cycle, 0 combinational latency; the other port gets rvalid = 0 and rdata = 0.
REQ-015 SHALL treat writes identically to reads; the write completion is membus.rvalid, with rdata ignored by the requester.
REQ-016 SHALL drop membus.rvalid when owner == NONE and route it to neither port.
REQ-017 SHALL support back-to-back operation: rvalid for owner X and a new grant to Y in the same cycle; owner becomes Y; throughput is 1 transaction per downstream latency.
REQ-018 SHALL hold a grant stable while membus.ready is low; the selection may change only if the selected requester deasserts valid. Requesters keep valid asserted until ready, per bus rules.
REQ-019 SHALL add no added latency: request path and response path are both purely combinational from the registered owner.

Reset
REQ-020 SHALL, while rst == 1 at a clock edge, set owner = NONE and last_grant = IFETCH, independent of in-flight traffic.
REQ-021 SHALL, while rst is asserted, drive all outputs (membus.valid, i/d ready, i/d rvalid) to 0 and data/address outputs to 0.
REQ-022 SHALL, after reset mid-transaction, discard any late membus.rvalid via REQ-016.

Structure
REQ-023 SHALL define enum MembusOwner {NONE, IFETCH, DATA} in shared package eei, for reuse by trace/debug logic.
REQ-024 SHALL take no new package constants; widths come from XLEN and MEMBUS_DATA_WIDTH in eei.
REQ-025 SHALL be implemented as a single module with no sub-module; one always_comb for the request mux, one for the response demux, one always_ff.

Verification
REQ-026 SHALL check: fetch only, addr 0x8000_0000, downstream rvalid 2 cycles later with rdata 0x13 -> i rvalid with 0x13, d rvalid 0, owner back to NONE.
REQ-027 SHALL check: same-cycle i (0x8000_0000) and d (0x8000_1000) with ALTERNATE = 0 -> d granted first, i granted in d's rvalid cycle, responses to correct ports in order.
REQ-028 SHALL check: ALTERNATE = 1, both valid continuously for 4 transactions -> grant order D, I, D, I.
REQ-029 SHALL check: d write to 0x4000_0000 with wmask 0x0F, wdata 0xDEADBEEF -> membus carries identical wen/wmask/wdata; d rvalid on completion; i untouched.
REQ-030 SHALL check: rst pulsed 1 cycle while owner == DATA, then downstream rvalid with rdata 0x55 -> neither port sees rvalid, owner stays NONE.
REQ-031 SHALL check: downstream ready held low 3 cycles with d valid -> membus.addr and membus.wdata are stable, d ready = 0, i ready = 0 throughout.
